// File: rtl/gray_stream_decoder.sv
// Gray-coded count stream receiver: decodes each accepted sample to binary,
// classifies the step against the previous value, tracks lock and counts errors.
module gray_stream_decoder #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned LOCK_STEPS = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] in_gray,
  input  logic                  in_valid,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] out_bin,
  output logic                  out_valid,
  output logic                  step_err,
  output logic                  locked,
  output logic [ERR_W-1:0]      err_cnt
);

  localparam int unsigned GW = $clog2(LOCK_STEPS + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         good_cnt, good_cnt_nxt;
  logic [GW-1:0]         good_inc;
  logic [DATA_WIDTH-1:0] bin;
  logic [DATA_WIDTH-1:0] delta;
  logic                  is_good;
  logic                  is_err;

  logic [DATA_WIDTH-1:0] out_bin_nxt;
  logic                  out_valid_nxt;
  logic                  step_err_nxt;
  logic                  locked_nxt;
  logic [ERR_W-1:0]      err_cnt_nxt;

  // Gray-to-binary: each binary bit is the XOR of the Gray bits at and above it
  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      bin[i] = ^(in_gray >> i);
    end
  end

  // Step classification against the last accepted value (modular difference)
  always_comb begin
    delta    = bin - out_bin;
    is_good  = (delta == DATA_WIDTH'(1));
    is_err   = !is_good && (delta != '0);
    good_inc = good_cnt + GW'(1);
  end

  // State register and good-step counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  // Next-state logic: only accepted samples move the FSM
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    if (in_valid) begin
      case (state)
        S_IDLE: begin
          state_nxt    = S_ACQUIRE;
          good_cnt_nxt = '0;
        end
        S_ACQUIRE: begin
          if (is_good) begin
            good_cnt_nxt = good_inc;
            if (good_inc == GW'(LOCK_STEPS)) state_nxt = S_LOCKED;
          end else if (is_err) begin
            good_cnt_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (is_err) begin
            state_nxt    = S_ACQUIRE;
            good_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = S_IDLE;
          good_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Output next values; the first sample after IDLE has no predecessor and never errors
  always_comb begin
    out_valid_nxt = in_valid;
    out_bin_nxt   = in_valid ? bin : out_bin;
    step_err_nxt  = in_valid && (state != S_IDLE) && is_err;
    locked_nxt    = (state_nxt == S_LOCKED);
    err_cnt_nxt   = err_cnt;
    if (err_clr) begin
      err_cnt_nxt = step_err_nxt ? ERR_W'(1) : '0;
    end else if (step_err_nxt && (err_cnt != ERR_MAX)) begin
      err_cnt_nxt = err_cnt + ERR_W'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_bin   <= '0;
      out_valid <= 1'b0;
      step_err  <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      out_bin   <= out_bin_nxt;
      out_valid <= out_valid_nxt;
      step_err  <= step_err_nxt;
      locked    <= locked_nxt;
      err_cnt   <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder (DATA_WIDTH=4, LOCK_STEPS=4, ERR_W=2).
module tb_gray_stream_decoder;

  logic       clk;
  logic       resetn;
  logic [3:0] in_gray;
  logic       in_valid;
  logic       err_clr;
  logic [3:0] out_bin;
  logic       out_valid;
  logic       step_err;
  logic       locked;
  logic [1:0] err_cnt;

  int n_cmp;
  int n_bad;

  gray_stream_decoder #(
    .DATA_WIDTH(4),
    .LOCK_STEPS(4),
    .ERR_W     (2)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_gray  (in_gray),
    .in_valid (in_valid),
    .err_clr  (err_clr),
    .out_bin  (out_bin),
    .out_valid(out_valid),
    .step_err (step_err),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] g_of(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // Drive one cycle of inputs; returns 1 ns after the capturing edge
  task automatic send(input logic [3:0] g, input logic v, input logic clr);
    in_gray  = g;
    in_valid = v;
    err_clr  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    resetn   = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    in_gray = 4'd0;
    do_reset();
    n_cmp++;
    if ({out_bin, out_valid, step_err, locked, err_cnt} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got bin=%0d v=%0b e=%0b l=%0b cnt=%0d want all 0",
               out_bin, out_valid, step_err, locked, err_cnt);
    end
  endtask

  // T1: full sweep 0..15,0,1 including wrap
  task automatic test_sweep();
    for (int i = 0; i < 18; i++) begin
      send(g_of(i % 16), 1'b1, 1'b0);
      n_cmp++;
      if (out_bin !== 4'(i % 16) || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL sweep_bin[%0d]: got bin=%0d v=%0b want bin=%0d v=1", i, out_bin, out_valid, i % 16);
      end
      n_cmp++;
      if (step_err !== 1'b0 || locked !== (i >= 4)) begin
        n_bad++;
        $display("FAIL sweep_flags[%0d]: got err=%0b lock=%0b want err=0 lock=%0b", i, step_err, locked, i >= 4);
      end
    end
    send(4'b1111, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || out_bin !== 4'd1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL sweep_idle: got v=%0b bin=%0d lock=%0b want v=0 bin=1 lock=1", out_valid, out_bin, locked);
    end
  endtask

  // T2: locked at 2, jump to 4, then relock at 8
  task automatic test_err_relock();
    send(g_of(2), 1'b1, 1'b0);
    n_cmp++;
    if (locked !== 1'b1 || out_bin !== 4'd2) begin
      n_bad++;
      $display("FAIL relock_pre: got lock=%0b bin=%0d want lock=1 bin=2", locked, out_bin);
    end
    send(4'b0110, 1'b1, 1'b0);
    n_cmp++;
    if (step_err !== 1'b1 || out_bin !== 4'd4 || err_cnt !== 2'd1 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL relock_err: got err=%0b bin=%0d cnt=%0d lock=%0b want err=1 bin=4 cnt=1 lock=0",
               step_err, out_bin, err_cnt, locked);
    end
    for (int b = 5; b <= 8; b++) begin
      send(g_of(b), 1'b1, 1'b0);
      n_cmp++;
      if (locked !== (b == 8) || step_err !== 1'b0 || out_bin !== 4'(b)) begin
        n_bad++;
        $display("FAIL relock_step[%0d]: got lock=%0b err=%0b bin=%0d want lock=%0b err=0 bin=%0d",
                 b, locked, step_err, out_bin, b == 8, b);
      end
    end
  endtask

  // T3: locked at 3, repeat gray 0010 three times
  task automatic test_hold();
    do_reset();
    send(g_of(15), 1'b1, 1'b0);
    for (int b = 0; b <= 3; b++) send(g_of(b), 1'b1, 1'b0);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_pre: got lock=%0b want 1", locked);
    end
    for (int k = 0; k < 3; k++) begin
      send(4'b0010, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || step_err !== 1'b0 || locked !== 1'b1 || out_bin !== 4'd3) begin
        n_bad++;
        $display("FAIL hold[%0d]: got v=%0b err=%0b lock=%0b bin=%0d want v=1 err=0 lock=1 bin=3",
                 k, out_valid, step_err, locked, out_bin);
      end
    end
    send(g_of(4), 1'b1, 1'b0);
    n_cmp++;
    if (locked !== 1'b1 || step_err !== 1'b0 || out_bin !== 4'd4) begin
      n_bad++;
      $display("FAIL hold_post: got lock=%0b err=%0b bin=%0d want lock=1 err=0 bin=4", locked, step_err, out_bin);
    end
  endtask

  // T4: saturation of a 2-bit error counter and clear behaviour
  task automatic test_err_sat();
    int seq [5] = '{10, 0, 8, 2, 12};
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      send(g_of(seq[k]), 1'b1, 1'b0);
      n_cmp++;
      if (step_err !== 1'b1 || err_cnt !== 2'(exp_cnt[k]) || locked !== 1'b0) begin
        n_bad++;
        $display("FAIL sat[%0d]: got err=%0b cnt=%0d lock=%0b want err=1 cnt=%0d lock=0",
                 k, step_err, err_cnt, locked, exp_cnt[k]);
      end
    end
    send(g_of(6), 1'b1, 1'b1);
    n_cmp++;
    if (step_err !== 1'b1 || err_cnt !== 2'd1 || out_bin !== 4'd6) begin
      n_bad++;
      $display("FAIL clr_with_err: got err=%0b cnt=%0d bin=%0d want err=1 cnt=1 bin=6", step_err, err_cnt, out_bin);
    end
    send(4'b0000, 1'b0, 1'b1);
    n_cmp++;
    if (err_cnt !== 2'd0 || out_valid !== 1'b0 || out_bin !== 4'd6) begin
      n_bad++;
      $display("FAIL clr_alone: got cnt=%0d v=%0b bin=%0d want cnt=0 v=0 bin=6", err_cnt, out_valid, out_bin);
    end
  endtask

  // T5: gaps in in_valid ignore in_gray
  task automatic test_valid_gaps();
    do_reset();
    send(4'b0001, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_bin !== 4'd1 || step_err !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_first: got v=%0b bin=%0d err=%0b want v=1 bin=1 err=0", out_valid, out_bin, step_err);
    end
    send(4'b1111, 1'b0, 1'b0);
    send(4'b0101, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || out_bin !== 4'd1 || step_err !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_idle: got v=%0b bin=%0d err=%0b want v=0 bin=1 err=0", out_valid, out_bin, step_err);
    end
    send(4'b0011, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_bin !== 4'd2 || step_err !== 1'b0 || err_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL gap_second: got v=%0b bin=%0d err=%0b cnt=%0d want v=1 bin=2 err=0 cnt=0",
               out_valid, out_bin, step_err, err_cnt);
    end
  endtask

  // T6: asynchronous reset while locked, then reacquire
  task automatic test_async_reset();
    for (int b = 3; b <= 5; b++) send(g_of(b), 1'b1, 1'b0);
    n_cmp++;
    if (locked !== 1'b1 || out_bin !== 4'd5) begin
      n_bad++;
      $display("FAIL areset_pre: got lock=%0b bin=%0d want lock=1 bin=5", locked, out_bin);
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({out_bin, out_valid, step_err, locked, err_cnt} !== 9'd0) begin
      n_bad++;
      $display("FAIL areset_async: got bin=%0d v=%0b e=%0b l=%0b cnt=%0d want all 0",
               out_bin, out_valid, step_err, locked, err_cnt);
    end
    #1 resetn = 1'b1;
    send(4'b1100, 1'b1, 1'b0);
    n_cmp++;
    if (out_bin !== 4'd8 || step_err !== 1'b0 || locked !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_first: got bin=%0d err=%0b lock=%0b v=%0b want bin=8 err=0 lock=0 v=1",
               out_bin, step_err, locked, out_valid);
    end
    for (int b = 9; b <= 12; b++) begin
      send(g_of(b), 1'b1, 1'b0);
      n_cmp++;
      if (locked !== (b == 12) || step_err !== 1'b0) begin
        n_bad++;
        $display("FAIL areset_reacq[%0d]: got lock=%0b err=%0b want lock=%0b err=0", b, locked, step_err, b == 12);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    resetn   = 1'b0;
    in_gray  = 4'd0;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    test_reset();
    test_sweep();
    test_err_relock();
    test_hold();
    test_err_sat();
    test_valid_gaps();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
